// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and queue defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } txq_state_t;

  localparam int TXQ_DEPTH_DEFAULT = 16;
  localparam int TXQ_BUSY_TIMEOUT  = 4;

endpackage

// File: rtl/sync_fifo_byte.sv
// Single-clock circular byte buffer with registered full/empty flags and an occupancy counter.
module sync_fifo_byte #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_next;
  logic          push;
  logic          pop;

  // A write against a registered full is dropped even when a pop frees space this cycle.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LVL_ONE;
    else if (!push && pop)
      level_next = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_next;
      full  <= (level_next == FULL_LVL);
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter handshake; UART_TXQ_OVF_EN adds overflow/drop_cnt reporting.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH = TXQ_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
`ifdef UART_TXQ_OVF_EN
  output logic          overflow,
  output logic [7:0]    drop_cnt,
`endif
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    byte_to_send
);

  localparam int TW = $clog2(TXQ_BUSY_TIMEOUT);
  localparam logic [TW-1:0] HI_LAST = TW'(TXQ_BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] HI_ONE  = TW'(1);

  txq_state_t    state;
  txq_state_t    state_next;
  logic          pop;
  logic [7:0]    head;
  logic [TW-1:0] hi_cnt;

  sync_fifo_byte #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:    if (!empty && !tx_busy) state_next = LOAD;
      LOAD: begin
        pop        = ~empty;
        state_next = START;
      end
      START:   state_next = WAIT_HI;
      // A transmitter that never answers the pulse must not wedge the queue.
      WAIT_HI: begin
        if (tx_busy)
          state_next = WAIT_LO;
        else if (hi_cnt == HI_LAST)
          state_next = IDLE;
      end
      WAIT_LO: if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      tx_start     <= 1'b0;
      byte_to_send <= 8'h00;
      hi_cnt       <= '0;
    end else begin
      state    <= state_next;
      tx_start <= (state_next == START);
      if (pop) byte_to_send <= head;
      hi_cnt   <= (state == WAIT_HI) ? hi_cnt + HI_ONE : '0;
    end
  end

`ifdef UART_TXQ_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a transmitter model and an expected-byte scoreboard.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] byte_to_send;
`ifdef UART_TXQ_OVF_EN
  logic       overflow;
  logic [7:0] drop_cnt;
`endif

  logic       busy_m    = 1'b0;
  logic       hold      = 1'b0;
  int         busy_len  = 10;
  int         busy_left = 0;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         starts = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic [7:0] sb [$];
  logic [7:0] sent = 8'h00;
  bit         stab_ok = 1'b0;

  assign tx_busy = busy_m | hold;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
`ifdef UART_TXQ_OVF_EN
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
`endif
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .byte_to_send (byte_to_send)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for busy_len cycles after each start pulse; busy_len=0 ignores pulses.
  always @(posedge clk) begin
    if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) busy_m <= 1'b0;
    end else if (tx_start && busy_len > 0) begin
      busy_m    <= 1'b1;
      busy_left <= busy_len;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("level_bound", 32'(level <= 5'(DEPTH)), 1);
      if (tx_start) begin
        prev_start = last_start;
        last_start = cyc;
        starts++;
        check("start_while_busy", 32'(tx_busy), 0);
        check("unexpected_start", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check("tx_byte", 32'(byte_to_send), 32'(sb.pop_front()));
        sent    = byte_to_send;
        stab_ok = 1'b1;
      end else if (tx_busy && stab_ok) begin
        check("byte_stable", 32'(byte_to_send), 32'(sent));
      end
    end else begin
      stab_ok = 1'b0;
    end
  end

  task automatic put(input logic [7:0] d, input bit accepted);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (accepted) sb.push_back(d);
  endtask

  task automatic wr_stop();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 6 && n < budget) begin
      @(negedge clk);
      n++;
      if (sb.size() == 0 && empty && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int wcyc;
    int n;

    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_level", 32'(level), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_byte", 32'(byte_to_send), 0);
`ifdef UART_TXQ_OVF_EN
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
    rst = 1'b1;

    // Single byte into an idle queue
    busy_len = 10;
    s0 = starts;
    put(8'h41, 1'b1);
    wr_stop();
    wcyc = cyc;
    check("wr_empty", 32'(empty), 0);
    check("wr_level", 32'(level), 1);
    wait_drain("drain1_timeout", 200);
    check("single_start_count", 32'(starts - s0), 1);
    check("start_latency", 32'(last_start - wcyc), 2);
    check("single_empty_after", 32'(empty), 1);

    // Fill to DEPTH while the transmitter is held busy, then overflow
    hold = 1'b1;
    s0 = starts;
    for (int i = 0; i < DEPTH; i++) put(8'h30 + 8'(i), 1'b1);
    put(8'hFF, 1'b0);
    wr_stop();
    check("burst_full", 32'(full), 1);
    check("burst_level", 32'(level), DEPTH);
`ifdef UART_TXQ_OVF_EN
    check("burst_overflow", 32'(overflow), 1);
    check("burst_drop_cnt", 32'(drop_cnt), 1);
`endif
    hold = 1'b0;
    wait_drain("drain2_timeout", 2000);
    check("burst_start_count", 32'(starts - s0), DEPTH);
    check("burst_empty_after", 32'(empty), 1);

    // Interleaved bursts across more than two pointer wraps
    busy_len = 3;
    s0 = starts;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 8; i++) put(8'h80 + 8'(b * 8 + i), 1'b1);
      wr_stop();
      n = 0;
      while (level > 5'd4 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("interleave_pace_timeout", 32'(n < 500), 1);
    end
    wait_drain("drain3_timeout", 2000);
    check("interleave_start_count", 32'(starts - s0), 48);
    check("interleave_level_after", 32'(level), 0);

    // Transmitter ignores the start pulse
    busy_len = 0;
    s0 = starts;
    put(8'hA1, 1'b1);
    put(8'hA2, 1'b1);
    wr_stop();
    wait_drain("drain4_timeout", 200);
    check("timeout_start_count", 32'(starts - s0), 2);
    check("timeout_spacing", 32'(last_start - prev_start), 7);

    // Reset during a long frame with bytes queued
    busy_len = 30;
    put(8'hC1, 1'b1);
    wr_stop();
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("frame_busy_timeout", 32'(n < 50), 1);
    for (int i = 0; i < 5; i++) put(8'hD0 + 8'(i), 1'b0);
    wr_stop();
    check("pre_reset_level", 32'(level), 5);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_full", 32'(full), 0);
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_byte", 32'(byte_to_send), 0);
    check("mid_rst_busy_held", 32'(tx_busy), 1);
`ifdef UART_TXQ_OVF_EN
    check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
`endif
    rst = 1'b1;
    s0 = starts;
    put(8'h55, 1'b1);
    wr_stop();
    wait_drain("drain5_timeout", 500);
    check("post_rst_start_count", 32'(starts - s0), 1);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
